// File: rtl/fetch_pkg.sv
// Shared ISA definitions for the 16-bit pipeline: opcodes, bubble word and fetch-stage types.
package fetch_pkg;

    localparam logic [3:0]  OP_NOP      = 4'b0000;
    localparam logic [3:0]  OP_HALT     = 4'b0001;
    localparam logic [3:0]  OP_BRANCH   = 4'b0010;
    localparam logic [3:0]  OP_JUMP     = 4'b0100;
    localparam logic [15:0] INST_BUBBLE = 16'h0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:12] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries between instruction memory and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC ownership, credit-limited in-order requests, wrong-path dropping,
// redirect handling and the RUN/HALTED control FSM.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [15:0] PC,
    output logic [15:0] PCPlus1,
    output logic [15:0] inst,
    output logic        halted
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic [15:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] drop_after_resp;

    logic             grant, resp_drop, halt_pop;
    logic             fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head, fifo_wdata;

    assign imem_addr  = fetch_pc_q;
    assign halted     = (state_q == ST_HALTED);
    assign fifo_wdata = '{pc: resp_pc_q, inst: imem_rdata};

    always_comb begin
        // Requests are held off while reset is asserted, even though the counters read zero.
        imem_req   = rst && (state_q == ST_RUN) &&
                     (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH));
        grant      = imem_req & imem_gnt;
        inst_valid = ~fifo_empty & ~redirect & (state_q == ST_RUN);
        fifo_pop   = inst_valid & ~stall;
        halt_pop   = fifo_pop & is_halt(fifo_head.inst);
        fifo_flush = redirect | halt_pop;
        resp_drop  = imem_rvalid && (drop_cnt_q != '0);
        fifo_push  = imem_rvalid & ~resp_drop & ~fifo_flush & (state_q == ST_RUN);
        PC         = inst_valid ? fifo_head.pc : resp_pc_q;
        PCPlus1    = PC + 16'd1;
        inst       = inst_valid ? fifo_head.inst : INST_BUBBLE;
    end

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = grant ? fetch_pc_q + 16'd1 : fetch_pc_q;
        resp_pc_d       = fifo_push ? resp_pc_q + 16'd1 : resp_pc_q;
        outstanding_d   = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
        drop_after_resp = resp_drop ? drop_cnt_q - CNT_W'(1) : drop_cnt_q;
        drop_cnt_d      = drop_after_resp;
        // Everything still in flight after this cycle, including a same-cycle grant, is wrong-path.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_cnt_d = drop_after_resp + outstanding_d;
            state_d    = ST_RUN;
        end else if (halt_pop) begin
            drop_cnt_d = drop_after_resp + outstanding_d;
            state_d    = ST_HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .flush(fifo_flush),
        .wdata(fifo_wdata),
        .rdata(fifo_head),
        .count(fifo_count),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage with a behavioural instruction memory of latency 1 or 2.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [15:0] imem_addr, imem_rdata;
    logic        redirect, stall;
    logic [15:0] redirect_pc;
    logic        inst_valid, halted;
    logic [15:0] PC, PCPlus1, inst;

    bit          lat2 = 1'b0;
    logic [15:0] halt_addr = 16'h0100;
    logic        s1v, s2v;
    logic [15:0] s1d, s2d;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(inst_valid), .PC(PC), .PCPlus1(PCPlus1), .inst(inst), .halted(halted)
    );

    // Memory contents: halt word at halt_addr, otherwise 0x8 opcode tagged with the low address bits.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == halt_addr) ? 16'h1000 : {4'h8, a[11:0]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
            s1d <= 16'h0;
            s2d <= 16'h0;
        end else begin
            s1v <= imem_req & imem_gnt;
            s1d <= mem_word(imem_addr);
            s2v <= s1v;
            s2d <= s1d;
        end
    end
    assign imem_rvalid = lat2 ? s2v : s1v;
    assign imem_rdata  = lat2 ? s2d : s1d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_present(output bit ok, output logic [47:0] obs);
        ok  = 1'b0;
        obs = '0;
        for (int b = 0; b < 40 && !ok; b++) begin
            if (inst_valid === 1'b1) begin
                obs = {PC, inst, PCPlus1};
                ok  = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        tick();
        tick();
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", inst_valid); else n_pass++;
        n_total++; if (inst !== 16'h0000) $display("FAIL reset_inst got=%h exp=0000", inst); else n_pass++;
        n_total++; if (PC !== 16'h0000) $display("FAIL reset_pc got=%h exp=0000", PC); else n_pass++;
        n_total++; if (PCPlus1 !== 16'h0001) $display("FAIL reset_pcplus1 got=%h exp=0001", PCPlus1); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else n_pass++;
    endtask

    task automatic test_stream();
        bit ok;
        logic [47:0] obs, exp;
        rst = 1'b1;
        #1;
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) $display("FAIL stream_first_req got=%b/%h exp=1/0000", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if ({inst_valid, imem_addr} !== {1'b0, 16'h0001}) $display("FAIL stream_cycle2 got=%b/%h exp=0/0001", inst_valid, imem_addr); else n_pass++;
        tick();
        n_total++; if (inst_valid !== 1'b1) $display("FAIL stream_cycle3_valid got=%b exp=1", inst_valid); else n_pass++;
        exp_pc = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            wait_present(ok, obs);
            exp = {exp_pc, mem_word(exp_pc), exp_pc + 16'd1};
            n_total++; if (!ok || obs !== exp) $display("FAIL stream_pres got=%h exp=%h", obs, exp); else n_pass++;
            exp_pc++;
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [47:0] obs, exp;
        stall = 1'b1;
        repeat (5) tick();
        n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if ({inst_valid, PC} !== {1'b1, exp_pc}) $display("FAIL stall_head got=%b/%h exp=1/%h", inst_valid, PC, exp_pc); else n_pass++;
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_present(ok, obs);
            exp = {exp_pc, mem_word(exp_pc), exp_pc + 16'd1};
            n_total++; if (!ok || obs !== exp) $display("FAIL stall_release_pres got=%h exp=%h", obs, exp); else n_pass++;
            exp_pc++;
        end
    endtask

    task automatic test_redirect();
        bit ok;
        logic [47:0] obs, exp;
        stall = 1'b1;
        repeat (8) tick();
        lat2 = 1'b1;
        stall = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'h0030;
        #1;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL redirect_masks_valid got=%b exp=0", inst_valid); else n_pass++;
        tick();
        redirect = 1'b0;
        #1;
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 16'h0030}) $display("FAIL redirect_req0 got=%b/%h exp=1/0030", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 16'h0031}) $display("FAIL redirect_req1 got=%b/%h exp=1/0031", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if ({imem_req, imem_rvalid} !== 2'b01) $display("FAIL redirect_two_outstanding got=%b exp=01", {imem_req, imem_rvalid}); else n_pass++;
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        exp_pc = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            wait_present(ok, obs);
            exp = {exp_pc, mem_word(exp_pc), exp_pc + 16'd1};
            n_total++; if (!ok || obs !== exp) $display("FAIL redirect_pres got=%h exp=%h", obs, exp); else n_pass++;
            exp_pc++;
        end
    endtask

    task automatic test_halt();
        bit ok;
        bit bad;
        logic [47:0] obs, exp;
        halt_addr = 16'h0003;
        redirect = 1'b1;
        redirect_pc = 16'h0000;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        exp_pc = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            wait_present(ok, obs);
            exp = (i == 3) ? {16'h0003, 16'h1000, 16'h0004} : {exp_pc, {4'h8, exp_pc[11:0]}, exp_pc + 16'd1};
            n_total++; if (!ok || obs !== exp) $display("FAIL halt_pres got=%h exp=%h", obs, exp); else n_pass++;
            exp_pc++;
        end
        n_total++; if ({halted, imem_req, inst_valid} !== 3'b100) $display("FAIL halt_enter got=%b exp=100", {halted, imem_req, inst_valid}); else n_pass++;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if ({halted, imem_req, inst_valid} !== 3'b100) bad = 1'b1;
        end
        n_total++; if (bad !== 1'b0) $display("FAIL halt_hold got=%b exp=0", bad); else n_pass++;
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        n_total++; if ({halted, imem_req, imem_addr} !== {2'b01, 16'h0010}) $display("FAIL halt_resume got=%b%b/%h exp=01/0010", halted, imem_req, imem_addr); else n_pass++;
        exp_pc = 16'h0010;
        for (int i = 0; i < 2; i++) begin
            wait_present(ok, obs);
            exp = {exp_pc, mem_word(exp_pc), exp_pc + 16'd1};
            n_total++; if (!ok || obs !== exp) $display("FAIL halt_resume_pres got=%h exp=%h", obs, exp); else n_pass++;
            exp_pc++;
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [47:0] obs, exp;
        logic [47:0] table_exp [4];
        table_exp[0] = {16'hFFFE, 16'h8FFE, 16'hFFFF};
        table_exp[1] = {16'hFFFF, 16'h8FFF, 16'h0000};
        table_exp[2] = {16'h0000, 16'h8000, 16'h0001};
        table_exp[3] = {16'h0001, 16'h8001, 16'h0002};
        halt_addr = 16'h0100;
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_present(ok, obs);
            exp = table_exp[i];
            n_total++; if (!ok || obs !== exp) $display("FAIL wrap_pres got=%h exp=%h", obs, exp); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [47:0] obs, exp;
        stall = 1'b1;
        repeat (8) tick();
        lat2 = 1'b0;
        stall = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'h0070;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 16'h0070}) $display("FAIL b2b_req0 got=%b/%h exp=1/0070", imem_req, imem_addr); else n_pass++;
        tick();
        n_total++; if ({imem_req, imem_rvalid, imem_addr} !== {2'b11, 16'h0071}) $display("FAIL b2b_grant_and_resp got=%b%b/%h exp=11/0071", imem_req, imem_rvalid, imem_addr); else n_pass++;
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        exp_pc = 16'h0080;
        for (int i = 0; i < 3; i++) begin
            wait_present(ok, obs);
            exp = {exp_pc, mem_word(exp_pc), exp_pc + 16'd1};
            n_total++; if (!ok || obs !== exp) $display("FAIL b2b_pres got=%h exp=%h", obs, exp); else n_pass++;
            exp_pc++;
        end
        n_total++; if (dut.drop_cnt_q !== '0) $display("FAIL b2b_drop_cnt got=%0d exp=0", dut.drop_cnt_q); else n_pass++;
    endtask

    initial begin
        imem_gnt    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        stall       = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
